// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter and its input conditioning.
package period_meter_pkg;

  localparam int unsigned DEF_CNT_WIDTH = 28;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEAS    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer, one delay flop and a rising-edge pulse.
// Reusable for any slow asynchronous input (key lines, divided clocks).
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic s_o,
  output logic rise_o
);

  logic       meta_q;
  logic       s_q;
  logic       s_dly_q;
  logic [2:0] fill_q;

  // Synchronize, delay, and track how far the pipeline has filled since reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
      fill_q  <= '0;
    end else begin
      meta_q  <= async_i;
      s_q     <= meta_q;
      s_dly_q <= s_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  // The flops clear to 0 on reset, so a line already high at release would
  // look like a 0->1 transition. Edges only count once s_dly_q holds a real
  // sample of the input, which keeps a constant-high input edge-free.
  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q & fill_q[2];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow periodic input in clock cycles,
// with a per-period valid strobe, lock indication and loss-of-signal timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT    = CNT_WIDTH'(50_000_000),
  parameter logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(4)
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic s;
  logic rise;

  state_e               state_q,  state_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q,   hcnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q,   high_d;
  logic                 valid_q,  valid_d;
  logic                 locked_q, locked_d;
  logic                 tmo_q,    tmo_d;
  logic                 accept;
  logic                 expired;

  sync_edge_detect u_sync (
    .clk_i   (clock_in),
    .rst_i   (reset),
    .async_i (sig_in),
    .s_o     (s),
    .rise_o  (rise)
  );

  // Edge qualification and timeout compare, both on the registered count.
  always_comb begin
    accept  = rise && ((state_q == ST_IDLE) || (state_q == ST_TIMEOUT) ||
                       (cnt_q >= MIN_PERIOD));
    expired = (cnt_q >= TIMEOUT);
  end

  // Period and high-time counters: restart at 1 on an accepted edge, else saturate upward.
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (accept) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (s && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end
    end
  end

  // Next-state and output logic; an accepted edge takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE, ST_ARMED, ST_MEAS: begin
        if (accept) begin
          if (state_q == ST_IDLE) begin
            state_d = ST_ARMED;
          end else begin
            state_d  = ST_MEAS;
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end
        end else if (expired) begin
          state_d  = ST_TIMEOUT;
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          period_d = '0;
          high_d   = '0;
        end
      end
      ST_TIMEOUT: begin
        if (accept) begin
          state_d = ST_ARMED;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus is a per-cycle level stream,
// a rise-to-rise reference model predicts reports and timeouts.
module tb_period_meter;

  localparam int unsigned W    = 16;
  localparam int          T    = 100;
  localparam int          MINP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig = 1'b0;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         pv;
  logic         locked;
  logic         tmo;

  period_meter #(
    .CNT_WIDTH  (W),
    .TIMEOUT    (16'd100),
    .MIN_PERIOD (16'd4)
  ) dut (
    .clock_in     (clk),
    .reset        (rst),
    .sig_in       (sig),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (pv),
    .locked       (locked),
    .timeout      (tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int period; int high; } rep_t;
  typedef struct { int cyc; bit window; } to_t;
  rep_t exp_q[$];
  to_t  to_q[$];

  int checks   = 0;
  int failures = 0;
  int lat      = -1;

  // Reference model state (level stream view).
  bit first_sample;
  bit prev;
  bit have_ref;
  bit m_to;
  bit m_locked;
  int last_acc;
  int rel_cyc;
  int hi;
  int m_period;
  int m_high;
  int m_chg;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void chk_rng(input string name, input longint act, input longint lo, input longint hi_lim);
    checks++;
    if (act < lo || act > hi_lim) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi_lim, cyc);
    end
  endfunction

  function automatic void model_reset();
    first_sample = 1;
    prev = 0; have_ref = 0; m_to = 0; m_locked = 0;
    last_acc = 0; rel_cyc = 0; hi = 0; m_period = 0; m_high = 0; m_chg = cyc;
  endfunction

  function automatic void enter_timeout();
    m_to = 1; m_locked = 0; m_period = 0; m_high = 0; m_chg = cyc;
  endfunction

  // One input level per clock: a period is the distance between accepted
  // rising edges, the high time is the number of high levels in between.
  function automatic void model_step(input bit lv);
    bit rise;
    int gap;
    if (first_sample) rel_cyc = cyc;
    rise = !first_sample && lv && !prev;
    first_sample = 0;
    gap = cyc - last_acc;
    if (!rise && !m_to) begin
      if (have_ref && gap == T) begin
        to_q.push_back('{cyc, 1'b0});
        enter_timeout();
      end else if (!have_ref && (cyc - rel_cyc) == T - 3) begin
        to_q.push_back('{cyc, 1'b1});
        enter_timeout();
      end
    end
    if (rise && (!have_ref || m_to || gap >= MINP)) begin
      if (have_ref && !m_to) begin
        exp_q.push_back('{cyc, gap, hi});
        m_locked = 1; m_period = gap; m_high = hi;
      end
      have_ref = 1; m_to = 0; last_acc = cyc; hi = 1; m_chg = cyc;
    end else begin
      hi += int'(lv);
    end
    prev = lv;
  endfunction

  task automatic drive(input bit lv);
    @(negedge clk);
    sig = lv;
    model_step(lv);
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) drive(i < h);
  endtask

  task automatic release_reset(input bit lv);
    @(negedge clk);
    rst = 1'b0;
    sig = lv;
    model_reset();
    model_step(lv);
  endtask

  task automatic async_reset(input bit lv_during, input int hold);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sig = lv_during;
    #1;
    chk("rst_period", period_out, 0);
    chk("rst_high", high_out, 0);
    chk("rst_valid", pv, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", tmo, 0);
    exp_q.delete();
    to_q.delete();
    repeat (hold) @(negedge clk);
  endtask

  task automatic settle_check(input bit lv, input string tag);
    int n;
    n = 0;
    do begin
      drive(lv);
      n++;
    end while ((n < 8 || (cyc - m_chg) < 8) && n < 400);
    chk({tag, "_locked"}, locked, m_locked);
    chk({tag, "_timeout"}, tmo, m_to);
    chk({tag, "_period"}, period_out, m_period);
    chk({tag, "_high"}, high_out, m_high);
  endtask

  // Monitor: pops the scoreboard on every strobe and every timeout assertion.
  rep_t me;
  to_t  mt;
  bit   tmo_prev = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pv) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe actual=1 required=0 period=%0d high=%0d (cycle %0d)", period_out, high_out, cyc);
        end else begin
          me = exp_q.pop_front();
          chk("strobe_period", period_out, me.period);
          chk("strobe_high", high_out, me.high);
          if (lat < 0) begin
            lat = cyc - me.cyc;
            chk_rng("strobe_latency_first", lat, 3, 4);
          end else begin
            chk("strobe_latency", cyc - me.cyc, lat);
          end
        end
      end
      if (tmo && !tmo_prev) begin
        if (to_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_timeout actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          mt = to_q.pop_front();
          if (mt.window) chk_rng("timeout_from_reset", cyc - mt.cyc, 2, 8);
          else if (lat >= 0) chk("timeout_latency", cyc - mt.cyc, lat);
          else chk_rng("timeout_latency", cyc - mt.cyc, 3, 4);
        end
      end
    end
    tmo_prev = tmo;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int h;
    int r;
    model_reset();
    #1;
    chk("init_period", period_out, 0);
    chk("init_valid", pv, 0);
    chk("init_locked", locked, 0);
    chk("init_timeout", tmo, 0);
    repeat (3) @(negedge clk);
    release_reset(1'b0);
    repeat (3) drive(1'b0);

    // Divider-style square wave, then a duty change.
    wave(8, 4, 6);
    settle_check(1'b0, "sq8");
    wave(10, 1, 4);
    settle_check(1'b0, "sq10");

    // Loss of signal, then recovery.
    repeat (130) drive(1'b0);
    settle_check(1'b0, "lost");
    wave(8, 4, 4);
    settle_check(1'b0, "resume");

    // Short glitch inside a period-12 wave, then edges at and below MIN_PERIOD.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 12; i++) drive(i == 0 || i == 2);
    wave(4, 1, 3);
    wave(3, 1, 4);
    settle_check(1'b0, "glitch");

    // Random periods, including gaps around the timeout boundary.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        p = T - 1 + $urandom_range(0, 3);
        h = $urandom_range(1, 5);
      end else if (r <= 2) begin
        p = $urandom_range(2, 5);
        h = $urandom_range(1, p - 1);
      end else begin
        p = $urandom_range(6, 20);
        h = $urandom_range(1, p - 1);
      end
      wave(p, h, 1);
    end
    wave(T, 3, 1);
    wave(T + 1, 3, 1);
    wave(9, 5, 3);
    settle_check(1'b0, "random");

    // Asynchronous reset in the middle of a period.
    wave(8, 4, 2);
    drive(1'b1);
    drive(1'b1);
    async_reset(1'b1, 3);
    release_reset(1'b0);
    repeat (3) drive(1'b0);
    wave(8, 4, 4);
    settle_check(1'b0, "postrst");

    // Input held high from reset: no edge, timeout only.
    async_reset(1'b1, 3);
    release_reset(1'b1);
    repeat (130) drive(1'b1);
    settle_check(1'b1, "held_high");

    chk("pending_strobes", exp_q.size(), 0);
    chk("pending_timeouts", to_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Receiving end of the divided-clock path: measures an incoming slow periodic signal in units of the system clock.
- Typical source is a divider output, e.g. a display scan clock or a key-scan strobe.
- Reports period length and high time per full cycle, with a valid strobe, a lock indication and a timeout when the signal stops toggling.
- Used for self-check of divider outputs and for measuring external square-wave inputs.

Parameters:
- CNT_WIDTH, 28: width of the period and high-time counters and outputs.
- TIMEOUT, 28'd50000000: cycles without an accepted rising edge before declaring loss of signal (1 s at 50 MHz).
- MIN_PERIOD, 28'd4: rising edges arriving fewer than MIN_PERIOD cycles after the last accepted edge are rejected as glitches.

Ports:
- clock_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sig_in  in  1  asynchronous signal under measurement.
- period_out  out  CNT_WIDTH  last measured period, in clock_in cycles.
- high_out  out  CNT_WIDTH  last measured high time, in clock_in cycles.
- period_valid  out  1  one-cycle strobe when period_out and high_out update.
- locked  out  1  at least one full period has been measured since the last reset or timeout.
- timeout  out  1  no accepted rising edge for TIMEOUT cycles.

Behaviour:
- Reset (async, active-high): all outputs 0, counters 0, synchronizer flops 0, state IDLE. Reset asserted mid-measurement discards the partial count.
- Input path:
  - sig_in passes through a 2-flop synchronizer to give s.
  - A third flop gives s_d.
  - rise = s & ~s_d.
  - Latency from a sig_in edge to rise is 2–3 cycles. It is constant, so periods are exact.
- Counters:
  - cnt: cycles since the last accepted rise. Loads 1 on the accepted-rise cycle, otherwise increments, saturating at all-ones.
  - hcnt: loads 1 on the accepted-rise cycle. On other cycles it increments (saturating) only while s is 1.
- Accepted rise: rise && (state==IDLE || state==TIMEOUT || cnt >= MIN_PERIOD). A rejected rise changes nothing; cnt and hcnt keep counting.
- State IDLE (after reset):
  - Accepted rise -> ARMED; cnt and hcnt load 1; no strobe.
  - cnt reaches TIMEOUT -> TIMEOUT.
- State ARMED (first edge seen):
  - Accepted rise -> MEAS; period_out<=cnt, high_out<=hcnt, period_valid=1 for the following cycle, locked<=1.
  - cnt reaches TIMEOUT -> TIMEOUT.
- State MEAS:
  - Each accepted rise: period_out<=cnt, high_out<=hcnt, period_valid pulses for one cycle.
  - cnt==TIMEOUT -> TIMEOUT.
- State TIMEOUT:
  - Entry: timeout<=1, locked<=0, period_out<=0, high_out<=0.
  - Accepted rise -> ARMED, timeout<=0. The next full period is needed before period_valid is issued again.
- Simultaneous events: if an accepted rise and the timeout condition occur in the same cycle, the rise wins. cnt is then below TIMEOUT by construction of the compare; the compare uses the registered cnt.
- Width rules:
  - A period of N cycles gives period_out=N exactly.
  - A high time of H cycles gives high_out=H.
  - Signals constantly high or low never produce a rise, so they end in TIMEOUT.
- period_valid is registered and is never asserted in IDLE, ARMED-entry or TIMEOUT.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE, ST_ARMED, ST_MEAS, ST_TIMEOUT; 2 bits) and the default CNT_WIDTH.
- One sub-module, sync_edge_detect: 2-flop synchronizer, delay flop and rise output, with async active-high reset. It is reusable for key inputs.
- Counters and the FSM live in period_meter.

Test Plan:
- sig_in square wave, period 8 cycles, high 4 (divider with DIVISOR=8) -> first rise gives no strobe. From the second rise on: period_out=8, high_out=4, period_valid pulses once every 8 cycles, locked=1.
- Duty change to period 10, high 1 -> next strobe gives period_out=10, high_out=1.
- TIMEOUT=100, sig_in held low after locking -> timeout=1 exactly 100 cycles after the last accepted rise; locked=0 and outputs 0. Resume the period-8 wave -> timeout=0 at the first rise, first strobe at the second rise.
- MIN_PERIOD=4, glitch of 1 cycle high occurring 2 cycles after a rise in a period-12 wave -> no strobe at the glitch; next strobe reports period_out=12, and high_out includes the glitch high cycle.
- Reset asserted mid-period, asynchronously between clock edges -> all outputs 0 immediately. After release, IDLE; the first two rises are needed before period_valid.
- sig_in held high from reset -> no rise, timeout=1 after TIMEOUT cycles; period_valid never asserts.
